// File: rtl/decode_ctl_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, format bit positions, control
// encodings and the packed control bundle carried by the decode stage.
package decode_ctl_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_IALU = 2'b01;
  localparam logic [1:0] ALU_ILL  = 2'b11;

  localparam logic [1:0] USEL_NONE  = 2'b00;
  localparam logic [1:0] USEL_LUI   = 2'b01;
  localparam logic [1:0] USEL_AUIPC = 2'b10;

  localparam logic [2:0] BJ_JUMP = 3'b011;
  localparam logic [2:0] BJ_NONE = 3'b010;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [1:0] u_sel;
    logic [5:0] i_format;
    logic [2:0] bj_type;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       muldiv;
    logic       illegal;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

  // Bundle sent downstream for anything undecodable so EX can raise a trap.
  function automatic ctl_t illegal_ctl();
    ctl_t c;
    c         = '0;
    c.bj_type = BJ_NONE;
    c.alu_op  = ALU_ILL;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctl_stage_decode.sv
// Pure combinational RV32I decoder: instruction word to control bundle,
// plus flags telling the hazard logic which source registers are read.
module decode_ctl_stage_decode
  import decode_ctl_stage_pkg::*;
#(
  parameter int unsigned MEXT_EN = 0
) (
  input  logic [31:0] inst,
  output ctl_t        ctl,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [5:0] fmt;
  logic       bad;
  logic       rd_used;
  ctl_t       base;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    base         = '0;
    base.bj_type = BJ_NONE;
    fmt          = '0;
    bad          = 1'b0;
    case (opcode)
      OP_R: begin
        fmt[FMT_R]     = 1'b1;
        base.reg_write = 1'b1;
        base.alu_op    = ALU_ADD;
        if (funct7 == F7_MULDIV && MEXT_EN != 0) begin
          base.muldiv = 1'b1;
        end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        fmt[FMT_I]     = 1'b1;
        base.alu_op    = ALU_IALU;
        base.alu_src   = 1'b1;
        base.reg_write = 1'b1;
      end
      OP_LOAD: begin
        fmt[FMT_I]      = 1'b1;
        base.alu_src    = 1'b1;
        base.reg_write  = 1'b1;
        base.mem_read   = 1'b1;
        base.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        fmt[FMT_S]     = 1'b1;
        base.alu_src   = 1'b1;
        base.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        fmt[FMT_B]   = 1'b1;
        base.bj_type = funct3;
        // funct3 010/011 are unassigned branch encodings
        bad          = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        fmt[FMT_J]     = 1'b1;
        base.bj_type   = BJ_JUMP;
        base.reg_write = 1'b1;
      end
      OP_JALR: begin
        fmt[FMT_I]     = 1'b1;
        base.bj_type   = BJ_JUMP;
        base.alu_src   = 1'b1;
        base.reg_write = 1'b1;
      end
      OP_LUI: begin
        fmt[FMT_U]     = 1'b1;
        base.u_sel     = USEL_LUI;
        base.alu_src   = 1'b1;
        base.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        fmt[FMT_U]     = 1'b1;
        base.u_sel     = USEL_AUIPC;
        base.alu_src   = 1'b1;
        base.reg_write = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    rs1_used = !bad && (fmt[FMT_R] || fmt[FMT_I] || fmt[FMT_S] || fmt[FMT_B]);
    rs2_used = !bad && (fmt[FMT_R] || fmt[FMT_S] || fmt[FMT_B]);
    rd_used  = !bad && (fmt[FMT_R] || fmt[FMT_I] || fmt[FMT_U] || fmt[FMT_J]);

    ctl          = base;
    ctl.i_format = fmt;
    ctl.rs1      = rs1_used ? inst[19:15] : 5'd0;
    ctl.rs2      = rs2_used ? inst[24:20] : 5'd0;
    ctl.rd       = rd_used  ? inst[11:7]  : 5'd0;
    if (bad) begin
      ctl = illegal_ctl();
    end
  end

endmodule

// File: rtl/decode_ctl_stage.sv
// Registered decode/control stage: decodes the fetched instruction, applies the
// load-use interlock and presents the bundle through an output reg plus skid reg.
module decode_ctl_stage
  import decode_ctl_stage_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned MEXT_EN = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PC_W-1:0]  o_pc,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [1:0]       o_u_sel,
  output logic [5:0]       o_i_format,
  output logic [2:0]       o_bj_type,
  output logic [1:0]       o_alu_op,
  output logic             o_mem_read,
  output logic             o_mem_to_reg,
  output logic             o_mem_write,
  output logic             o_alu_src,
  output logic             o_reg_write,
  output logic             o_muldiv,
  output logic             o_illegal,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  ctl_t            dec_ctl;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  logic            accept;

  logic            out_valid_q, out_valid_d;
  ctl_t            out_ctl_q, out_ctl_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  ctl_t            skid_ctl_q, skid_ctl_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  decode_ctl_stage_decode #(.MEXT_EN(MEXT_EN)) u_decode (
    .inst     (i_inst),
    .ctl      (dec_ctl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // Load-use interlock: the loaded value is not forwardable until next cycle.
  assign hazard = i_valid && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                  ((rs1_used && dec_ctl.rs1 == i_ex_rd) ||
                   (rs2_used && dec_ctl.rs2 == i_ex_rd));
  assign o_ready = !skid_valid_q && !hazard;
  assign accept  = i_valid && o_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctl_d    = out_ctl_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ctl_d   = skid_ctl_q;
    skid_pc_d    = skid_pc_q;
    stall_cnt_d  = stall_cnt_q;

    if (hazard && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || i_ready) begin
      // Skid is only ever full while the output is held, and ready is low then.
      if (skid_valid_q) begin
        out_ctl_d    = skid_ctl_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_ctl_d   = dec_ctl;
        out_pc_d    = i_pc;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_ctl_d   = dec_ctl;
      skid_pc_d    = i_pc;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q  <= 1'b0;
      out_ctl_q    <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_ctl_q   <= '0;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ctl_q    <= out_ctl_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ctl_q   <= skid_ctl_d;
      skid_pc_q    <= skid_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_valid      = out_valid_q;
  assign o_pc         = out_pc_q;
  assign o_rs1        = out_ctl_q.rs1;
  assign o_rs2        = out_ctl_q.rs2;
  assign o_rd         = out_ctl_q.rd;
  assign o_u_sel      = out_ctl_q.u_sel;
  assign o_i_format   = out_ctl_q.i_format;
  assign o_bj_type    = out_ctl_q.bj_type;
  assign o_alu_op     = out_ctl_q.alu_op;
  assign o_mem_read   = out_ctl_q.mem_read;
  assign o_mem_to_reg = out_ctl_q.mem_to_reg;
  assign o_mem_write  = out_ctl_q.mem_write;
  assign o_alu_src    = out_ctl_q.alu_src;
  assign o_reg_write  = out_ctl_q.reg_write;
  assign o_muldiv     = out_ctl_q.muldiv;
  assign o_illegal    = out_ctl_q.illegal;
  assign o_stall      = hazard;
  assign o_stall_cnt  = stall_cnt_q;

endmodule
